// File: rtl/control_unit_seq.sv
// Hardwired Moore sequencer for the 32-bit bus datapath: fetch T0-T2, DECODE, execute T3-T6.
// Latency: one control step per Clock; strobes are registered and take effect the cycle the state is entered.
// Backpressure: Stop parks the machine in HOLD only when T0 would be entered; HALT is left only by Reset_n.
module control_unit_seq #(
  parameter int OPW   = 5,
  parameter int RSELW = 4
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [31:0]      IR,
  input  logic             Stop,
  output logic             PCout,
  output logic             MARin,
  output logic             IncPC,
  output logic             PCin,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Yin,
  output logic             Zin,
  output logic             ZLOout,
  output logic             ZHIout,
  output logic             HIin,
  output logic             LOin,
  output logic             HIout,
  output logic             LOout,
  output logic             Cout,
  output logic             Rout,
  output logic [RSELW-1:0] rout_sel,
  output logic             Rin,
  output logic [RSELW-1:0] rin_sel,
  output logic [OPW-1:0]   alu_op,
  output logic             Run,
  output logic             illegal_op,
  output logic [4:0]       state
);

  typedef enum logic [4:0] {
    S_RESET = 5'd0,
    S_T0    = 5'd1,
    S_T1    = 5'd2,
    S_T2    = 5'd3,
    S_DEC   = 5'd4,
    S_T3    = 5'd5,
    S_T4    = 5'd6,
    S_T5    = 5'd7,
    S_T6    = 5'd8,
    S_HOLD  = 5'd9,
    S_HALT  = 5'd10
  } state_t;

  // Instruction classes sharing one execute step pattern.
  typedef enum logic [2:0] {
    K_R, K_IMM, K_MD, K_UN, K_MF, K_NOP, K_HALT, K_ILL
  } klass_t;

  typedef struct packed {
    logic             pc_out;
    logic             mar_in;
    logic             inc_pc;
    logic             pc_in;
    logic             read;
    logic             mdr_in;
    logic             mdr_out;
    logic             ir_in;
    logic             y_in;
    logic             z_in;
    logic             zlo_out;
    logic             zhi_out;
    logic             hi_in;
    logic             lo_in;
    logic             hi_out;
    logic             lo_out;
    logic             c_out;
    logic             r_out;
    logic [RSELW-1:0] rout_sel;
    logic             r_in;
    logic [RSELW-1:0] rin_sel;
    logic [OPW-1:0]   alu_op;
    logic             run;
  } ctl_t;

  state_t           cur;
  state_t           nxt;
  ctl_t             ctl;
  klass_t           klass;
  logic [OPW-1:0]   op;
  logic [RSELW-1:0] ra;
  logic [RSELW-1:0] rb;
  logic [RSELW-1:0] rc;
  logic             ir_unused;

  assign op        = IR[31 -: OPW];
  assign ra        = IR[26 -: RSELW];
  assign rb        = IR[22 -: RSELW];
  assign rc        = IR[18 -: RSELW];
  assign ir_unused = ^IR[14:0];

  function automatic klass_t classify(input logic [OPW-1:0] o);
    if (o inside {[5'd3:5'd11]})       return K_R;
    if (o inside {[5'd12:5'd14]})      return K_IMM;
    if (o inside {5'd15, 5'd16})       return K_MD;
    if (o inside {5'd17, 5'd18})       return K_UN;
    if (o inside {5'd24, 5'd25})       return K_MF;
    if (o == 5'd26)                    return K_NOP;
    if (o == 5'd27)                    return K_HALT;
    return K_ILL;
  endfunction

  // Strobe set for a given step; only one bus source is ever driven per step.
  function automatic ctl_t ctl_for(input state_t s, input klass_t k, input logic [OPW-1:0] o,
                                   input logic [RSELW-1:0] a, input logic [RSELW-1:0] b,
                                   input logic [RSELW-1:0] cs);
    ctl_t c;
    c = '0;
    case (s)
      S_T0: begin
        c.run = 1'b1; c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.z_in = 1'b1;
      end
      S_T1: begin
        c.run = 1'b1; c.zlo_out = 1'b1; c.pc_in = 1'b1; c.read = 1'b1; c.mdr_in = 1'b1;
      end
      S_T2: begin
        c.run = 1'b1; c.mdr_out = 1'b1; c.ir_in = 1'b1;
      end
      S_DEC: c.run = 1'b1;
      S_T3: begin
        c.run = 1'b1;
        case (k)
          K_R, K_IMM: begin c.r_out = 1'b1; c.rout_sel = b; c.y_in = 1'b1; end
          K_MD:       begin c.r_out = 1'b1; c.rout_sel = a; c.y_in = 1'b1; end
          K_UN:       begin c.r_out = 1'b1; c.rout_sel = b; c.z_in = 1'b1; c.alu_op = o; end
          K_MF: begin
            // mfhi is 11000, mflo is 11001: bit 0 picks the source.
            c.hi_out = ~o[0]; c.lo_out = o[0]; c.r_in = 1'b1; c.rin_sel = a;
          end
          default: ;
        endcase
      end
      S_T4: begin
        c.run = 1'b1;
        case (k)
          K_R:   begin c.r_out = 1'b1; c.rout_sel = cs; c.z_in = 1'b1; c.alu_op = o; end
          K_IMM: begin c.c_out = 1'b1; c.z_in = 1'b1; c.alu_op = o; end
          K_MD:  begin c.r_out = 1'b1; c.rout_sel = b; c.z_in = 1'b1; c.alu_op = o; end
          K_UN:  begin c.zlo_out = 1'b1; c.r_in = 1'b1; c.rin_sel = a; end
          default: ;
        endcase
      end
      S_T5: begin
        c.run = 1'b1;
        case (k)
          K_R, K_IMM: begin c.zlo_out = 1'b1; c.r_in = 1'b1; c.rin_sel = a; end
          K_MD:       begin c.zlo_out = 1'b1; c.lo_in = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        c.run = 1'b1; c.zhi_out = 1'b1; c.hi_in = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  assign klass = classify(op);

  // Step sequencing; every path that would land in T0 diverts to HOLD while Stop is high.
  always_comb begin
    state_t entry;
    entry = Stop ? S_HOLD : S_T0;
    nxt   = cur;
    case (cur)
      S_RESET: nxt = entry;
      S_T0:    nxt = S_T1;
      S_T1:    nxt = S_T2;
      S_T2:    nxt = S_DEC;
      S_DEC: begin
        case (klass)
          K_NOP, K_ILL: nxt = entry;
          K_HALT:       nxt = S_HALT;
          default:      nxt = S_T3;
        endcase
      end
      S_T3:    nxt = (klass == K_MF) ? entry : S_T4;
      S_T4:    nxt = (klass == K_UN) ? entry : S_T5;
      S_T5:    nxt = (klass == K_MD) ? S_T6 : entry;
      S_T6:    nxt = entry;
      S_HOLD:  nxt = Stop ? S_HOLD : S_T0;
      S_HALT:  nxt = S_HALT;
      default: nxt = S_RESET;
    endcase
  end

  // State and registered strobes; reset clears both without waiting for a clock edge.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      cur <= S_RESET;
      ctl <= '0;
    end else begin
      cur <= nxt;
      ctl <= ctl_for(nxt, klass, op, ra, rb, rc);
    end
  end

  // IR is only loaded on the T2->DECODE edge, so the illegal flag must look at IR during DECODE itself.
  assign illegal_op = (cur == S_DEC) && (klass == K_ILL);

  assign PCout    = ctl.pc_out;
  assign MARin    = ctl.mar_in;
  assign IncPC    = ctl.inc_pc;
  assign PCin     = ctl.pc_in;
  assign Read     = ctl.read;
  assign MDRin    = ctl.mdr_in;
  assign MDRout   = ctl.mdr_out;
  assign IRin     = ctl.ir_in;
  assign Yin      = ctl.y_in;
  assign Zin      = ctl.z_in;
  assign ZLOout   = ctl.zlo_out;
  assign ZHIout   = ctl.zhi_out;
  assign HIin     = ctl.hi_in;
  assign LOin     = ctl.lo_in;
  assign HIout    = ctl.hi_out;
  assign LOout    = ctl.lo_out;
  assign Cout     = ctl.c_out;
  assign Rout     = ctl.r_out;
  assign rout_sel = ctl.rout_sel;
  assign Rin      = ctl.r_in;
  assign rin_sel  = ctl.rin_sel;
  assign alu_op   = ctl.alu_op;
  assign Run      = ctl.run;
  assign state    = cur;

endmodule

// File: tb/tb_control_unit_seq.sv
// Bench for control_unit_seq: per-cycle expected control words queued per scenario, compared each step.
module tb_control_unit_seq;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic [31:0] IR = 32'h0;
  logic        Stop = 1'b0;
  logic PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
  logic Yin, Zin, ZLOout, ZHIout, HIin, LOin, HIout, LOout, Cout;
  logic Rout, Rin, Run, illegal_op;
  logic [3:0] rout_sel, rin_sel;
  logic [4:0] alu_op, state;

  control_unit_seq dut (
    .Clock(Clock), .Reset_n(Reset_n), .IR(IR), .Stop(Stop),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .ZLOout(ZLOout), .ZHIout(ZHIout), .HIin(HIin), .LOin(LOin), .HIout(HIout),
    .LOout(LOout), .Cout(Cout), .Rout(Rout), .rout_sel(rout_sel), .Rin(Rin),
    .rin_sel(rin_sel), .alu_op(alu_op), .Run(Run), .illegal_op(illegal_op), .state(state)
  );

  always #5 Clock = ~Clock;

  localparam logic [4:0] S_RESET = 5'd0, S_T0 = 5'd1, S_T1 = 5'd2, S_T2 = 5'd3, S_DEC = 5'd4,
                         S_T3 = 5'd5, S_T4 = 5'd6, S_T5 = 5'd7, S_T6 = 5'd8,
                         S_HOLD = 5'd9, S_HALT = 5'd10;

  localparam logic [18:0] M_PCOUT = 19'h40000, M_MARIN = 19'h20000, M_INCPC = 19'h10000,
                          M_PCIN = 19'h08000, M_READ = 19'h04000, M_MDRIN = 19'h02000,
                          M_MDROUT = 19'h01000, M_IRIN = 19'h00800, M_YIN = 19'h00400,
                          M_ZIN = 19'h00200, M_ZLOOUT = 19'h00100, M_ZHIOUT = 19'h00080,
                          M_HIIN = 19'h00040, M_LOIN = 19'h00020, M_HIOUT = 19'h00010,
                          M_LOOUT = 19'h00008, M_COUT = 19'h00004, M_ROUT = 19'h00002,
                          M_RIN = 19'h00001, M_NONE = 19'h00000;
  localparam logic [18:0] F0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
  localparam logic [18:0] F1 = M_ZLOOUT | M_PCIN | M_READ | M_MDRIN;
  localparam logic [18:0] F2 = M_MDROUT | M_IRIN;

  typedef struct packed {
    logic [4:0]  st;
    logic [18:0] strb;
    logic [3:0]  rs;
    logic [3:0]  ws;
    logic [4:0]  alu;
    logic        run;
    logic        ill;
  } obs_t;

  obs_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic obs_t mk(input logic [4:0] st, input logic [18:0] s, input logic [3:0] rs,
                              input logic [3:0] ws, input logic [4:0] alu, input logic run,
                              input logic ill);
    obs_t o;
    o.st = st; o.strb = s; o.rs = rs; o.ws = ws; o.alu = alu; o.run = run; o.ill = ill;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.st   = state;
    o.strb = {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, Zin,
              ZLOout, ZHIout, HIin, LOin, HIout, LOout, Cout, Rout, Rin};
    o.rs   = rout_sel;
    o.ws   = rin_sel;
    o.alu  = alu_op;
    o.run  = Run;
    o.ill  = illegal_op;
    return o;
  endfunction

  function automatic logic [31:0] mkir(input logic [4:0] op, input logic [3:0] a,
                                       input logic [3:0] b, input logic [3:0] c);
    return {op, a, b, c, 15'd0};
  endfunction

  function automatic obs_t idle(input logic [4:0] st);
    return mk(st, M_NONE, 4'd0, 4'd0, 5'd0, 1'b0, 1'b0);
  endfunction

  function automatic obs_t t0();
    return mk(S_T0, F0, 4'd0, 4'd0, 5'd0, 1'b1, 1'b0);
  endfunction

  task automatic push_fetch(input logic ill);
    sb.push_back(mk(S_T1, F1, 4'd0, 4'd0, 5'd0, 1'b1, 1'b0));
    sb.push_back(mk(S_T2, F2, 4'd0, 4'd0, 5'd0, 1'b1, 1'b0));
    sb.push_back(mk(S_DEC, M_NONE, 4'd0, 4'd0, 5'd0, 1'b1, ill));
  endtask

  task automatic test_reset();
    obs_t e, g;
    Reset_n = 1'b0; Stop = 1'b0; IR = 32'h1B1A0000;
    repeat (2) @(posedge Clock);
    #1;
    sb.push_back(idle(S_RESET));
    e = sb.pop_front();
    g = sample();
    n_tests++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL reset: got %h, expected %h", g, e);
    end
    Reset_n = 1'b1;
  endtask

  // add R6,R3,R4 from reset release through back to T0.
  task automatic test_add();
    obs_t e, g;
    int i;
    sb.push_back(t0());
    push_fetch(1'b0);
    sb.push_back(mk(S_T3, M_ROUT | M_YIN, 4'd3, 4'd0, 5'd0, 1'b1, 1'b0));
    sb.push_back(mk(S_T4, M_ROUT | M_ZIN, 4'd4, 4'd0, 5'd3, 1'b1, 1'b0));
    sb.push_back(mk(S_T5, M_ZLOOUT | M_RIN, 4'd0, 4'd6, 5'd0, 1'b1, 1'b0));
    sb.push_back(t0());
    i = 0;
    while (sb.size() > 0) begin
      @(posedge Clock); #1;
      e = sb.pop_front();
      g = sample();
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL add step %0d: got %h, expected %h", i, g, e);
      end
      i++;
    end
  endtask

  task automatic test_mul();
    obs_t e, g;
    int i;
    IR = 32'h78B00000;
    push_fetch(1'b0);
    sb.push_back(mk(S_T3, M_ROUT | M_YIN, 4'd1, 4'd0, 5'd0, 1'b1, 1'b0));
    sb.push_back(mk(S_T4, M_ROUT | M_ZIN, 4'd6, 4'd0, 5'd15, 1'b1, 1'b0));
    sb.push_back(mk(S_T5, M_ZLOOUT | M_LOIN, 4'd0, 4'd0, 5'd0, 1'b1, 1'b0));
    sb.push_back(mk(S_T6, M_ZHIOUT | M_HIIN, 4'd0, 4'd0, 5'd0, 1'b1, 1'b0));
    sb.push_back(t0());
    i = 0;
    while (sb.size() > 0) begin
      @(posedge Clock); #1;
      e = sb.pop_front();
      g = sample();
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL mul step %0d: got %h, expected %h", i, g, e);
      end
      i++;
    end
  endtask

  task automatic test_addi();
    obs_t e, g;
    int i;
    IR = 32'h63000005;
    push_fetch(1'b0);
    sb.push_back(mk(S_T3, M_ROUT | M_YIN, 4'd0, 4'd0, 5'd0, 1'b1, 1'b0));
    sb.push_back(mk(S_T4, M_COUT | M_ZIN, 4'd0, 4'd0, 5'd12, 1'b1, 1'b0));
    sb.push_back(mk(S_T5, M_ZLOOUT | M_RIN, 4'd0, 4'd6, 5'd0, 1'b1, 1'b0));
    sb.push_back(t0());
    i = 0;
    while (sb.size() > 0) begin
      @(posedge Clock); #1;
      e = sb.pop_front();
      g = sample();
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL addi step %0d: got %h, expected %h", i, g, e);
      end
      i++;
    end
  endtask

  // Stop raised in T5 of an add: HOLD twice, then T0 on the first edge with Stop low.
  task automatic test_stop();
    obs_t e, g;
    int i;
    IR = 32'h1B1A0000;
    push_fetch(1'b0);
    sb.push_back(mk(S_T3, M_ROUT | M_YIN, 4'd3, 4'd0, 5'd0, 1'b1, 1'b0));
    sb.push_back(mk(S_T4, M_ROUT | M_ZIN, 4'd4, 4'd0, 5'd3, 1'b1, 1'b0));
    sb.push_back(mk(S_T5, M_ZLOOUT | M_RIN, 4'd0, 4'd6, 5'd0, 1'b1, 1'b0));
    sb.push_back(idle(S_HOLD));
    sb.push_back(idle(S_HOLD));
    sb.push_back(t0());
    i = 0;
    while (sb.size() > 0) begin
      @(posedge Clock); #1;
      e = sb.pop_front();
      g = sample();
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL stop step %0d: got %h, expected %h", i, g, e);
      end
      if (i == 5) Stop = 1'b1;
      if (i == 7) Stop = 1'b0;
      i++;
    end
  endtask

  // neg, mflo, mfhi (R0 target), nop, and: IR advanced each time T0 is reached.
  task automatic test_back_to_back();
    obs_t e, g;
    int i;
    logic [31:0] irq[$];
    irq.push_back(mkir(5'd17, 4'd2, 4'd5, 4'd0));
    irq.push_back(mkir(5'd25, 4'd9, 4'd0, 4'd0));
    irq.push_back(mkir(5'd24, 4'd0, 4'd0, 4'd0));
    irq.push_back(mkir(5'd26, 4'd0, 4'd0, 4'd0));
    irq.push_back(32'h2B1A0000);
    push_fetch(1'b0);
    sb.push_back(mk(S_T3, M_ROUT | M_ZIN, 4'd5, 4'd0, 5'd17, 1'b1, 1'b0));
    sb.push_back(mk(S_T4, M_ZLOOUT | M_RIN, 4'd0, 4'd2, 5'd0, 1'b1, 1'b0));
    sb.push_back(t0());
    push_fetch(1'b0);
    sb.push_back(mk(S_T3, M_LOOUT | M_RIN, 4'd0, 4'd9, 5'd0, 1'b1, 1'b0));
    sb.push_back(t0());
    push_fetch(1'b0);
    sb.push_back(mk(S_T3, M_HIOUT | M_RIN, 4'd0, 4'd0, 5'd0, 1'b1, 1'b0));
    sb.push_back(t0());
    push_fetch(1'b0);
    sb.push_back(t0());
    push_fetch(1'b0);
    sb.push_back(mk(S_T3, M_ROUT | M_YIN, 4'd3, 4'd0, 5'd0, 1'b1, 1'b0));
    sb.push_back(mk(S_T4, M_ROUT | M_ZIN, 4'd4, 4'd0, 5'd5, 1'b1, 1'b0));
    sb.push_back(mk(S_T5, M_ZLOOUT | M_RIN, 4'd0, 4'd6, 5'd0, 1'b1, 1'b0));
    sb.push_back(t0());
    IR = irq.pop_front();
    i = 0;
    while (sb.size() > 0) begin
      @(posedge Clock); #1;
      e = sb.pop_front();
      g = sample();
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL back_to_back step %0d: got %h, expected %h", i, g, e);
      end
      if (e.st == S_T0 && irq.size() > 0) IR = irq.pop_front();
      i++;
    end
  endtask

  task automatic test_illegal();
    obs_t e, g;
    int i;
    IR = 32'hF8000000;
    push_fetch(1'b1);
    sb.push_back(t0());
    i = 0;
    while (sb.size() > 0) begin
      @(posedge Clock); #1;
      e = sb.pop_front();
      g = sample();
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL illegal step %0d: got %h, expected %h", i, g, e);
      end
      i++;
    end
  endtask

  task automatic test_halt();
    obs_t e, g;
    int i;
    IR = 32'hD8000000;
    push_fetch(1'b0);
    for (int k = 0; k < 20; k++) sb.push_back(idle(S_HALT));
    i = 0;
    while (sb.size() > 0) begin
      @(posedge Clock); #1;
      e = sb.pop_front();
      g = sample();
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL halt step %0d: got %h, expected %h", i, g, e);
      end
      i++;
    end
  endtask

  // Reset out of HALT, then again mid-T4 of an add, checked between clock edges.
  task automatic test_mid_reset();
    obs_t e, g;
    int i;
    Reset_n = 1'b0;
    #1;
    sb.push_back(idle(S_RESET));
    e = sb.pop_front();
    g = sample();
    n_tests++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL reset_from_halt: got %h, expected %h", g, e);
    end
    @(posedge Clock); #1;
    Reset_n = 1'b1;
    IR = 32'h1B1A0000;
    sb.push_back(t0());
    push_fetch(1'b0);
    sb.push_back(mk(S_T3, M_ROUT | M_YIN, 4'd3, 4'd0, 5'd0, 1'b1, 1'b0));
    sb.push_back(mk(S_T4, M_ROUT | M_ZIN, 4'd4, 4'd0, 5'd3, 1'b1, 1'b0));
    i = 0;
    while (sb.size() > 0) begin
      @(posedge Clock); #1;
      e = sb.pop_front();
      g = sample();
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL mid_reset run-up step %0d: got %h, expected %h", i, g, e);
      end
      i++;
    end
    Reset_n = 1'b0;
    #1;
    sb.push_back(idle(S_RESET));
    e = sb.pop_front();
    g = sample();
    n_tests++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL mid_reset async clear: got %h, expected %h", g, e);
    end
    #1;
    Reset_n = 1'b1;
    sb.push_back(t0());
    sb.push_back(mk(S_T1, F1, 4'd0, 4'd0, 5'd0, 1'b1, 1'b0));
    i = 0;
    while (sb.size() > 0) begin
      @(posedge Clock); #1;
      e = sb.pop_front();
      g = sample();
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL mid_reset restart step %0d: got %h, expected %h", i, g, e);
      end
      i++;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_addi();
    test_stop();
    test_back_to_back();
    test_illegal();
    test_halt();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_tests);
    $fatal(1, "timeout");
  end

endmodule
